// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared constants for the memory-port arbiter: FSM state encoding, port
// identifiers and a small saturating-increment helper for the starve counter.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_ACCESS = 2'b01,
        ARB_RESP   = 2'b10
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    // Saturating 4-bit increment; never exceeds lim.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
        logic [3:0] r;
        if (v < lim) begin
            r = v + 4'd1;
        end else begin
            r = lim;
        end
        return r;
    endfunction

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_sel.sv
// -----------------------------------------------------------------------------
// arb_priority_sel
// Combinational winner selection for the two-port memory arbiter, plus the
// next value of the starve counter assuming the selection is taken.
//   req0, req1    : pending requests (CPU, DMA)
//   starve_cnt    : consecutive CPU wins over a pending DMA request
//   grant_valid   : at least one request present
//   winner        : PORT_CPU or PORT_DMA
//   starve_nxt    : starve counter value to register if the grant is taken
// -----------------------------------------------------------------------------
module arb_priority_sel
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] starve_cnt,
    output logic       grant_valid,
    output logic       winner,
    output logic [3:0] starve_nxt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    // Fixed CPU priority, overridden for DMA once the CPU has won LIMIT times in a row.
    always_comb begin
        grant_valid = req0 | req1;
        winner      = PORT_CPU;
        starve_nxt  = starve_cnt;
        case ({req1, req0})
            2'b01: begin
                winner     = PORT_CPU;
                starve_nxt = starve_cnt;
            end
            2'b10: begin
                winner     = PORT_DMA;
                starve_nxt = 4'd0;
            end
            2'b11: begin
                // >= rather than == so a corrupted counter above the limit still favours DMA
                if (starve_cnt >= LIMIT) begin
                    winner     = PORT_DMA;
                    starve_nxt = 4'd0;
                end else begin
                    winner     = PORT_CPU;
                    starve_nxt = sat_inc4(starve_cnt, LIMIT);
                end
            end
            default: begin
                winner     = PORT_CPU;
                starve_nxt = starve_cnt;
            end
        endcase
    end

endmodule : arb_priority_sel

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one memory port between the CPU (port 0) and a DMA/IO master
// (port 1). CPU has fixed priority; a starve counter forces a DMA grant after
// STARVE_LIMIT consecutive CPU wins over a pending DMA request. Each access is
// IDLE -> ACCESS (until mem_ready or TIMEOUT cycles) -> RESP (done/err pulse).
//   clk, rst                    : clock, synchronous active-high reset
//   reqN/weN/addrN/wdataN       : requester N command, held until doneN/errN
//   doneN/errN                  : one-cycle completion / timeout-abort pulse
//   rdataN                      : read data, updated on a successful read
//   mem_en/we/addr/wdata        : registered memory command
//   mem_rdata, mem_ready        : memory response
//   owner                       : port owning the current/last access
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              owner
);

    // Abort fires on the cycle whose count would reach TIMEOUT.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    arb_state_t        state_r, state_nxt_s;
    logic [3:0]        starve_cnt_r, starve_nxt_s;
    logic [7:0]        timeout_cnt_r, timeout_nxt_s;
    logic              owner_r, owner_nxt_s;
    logic              mem_en_r, mem_en_nxt_s;
    logic              mem_we_r, mem_we_nxt_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_nxt_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_nxt_s;
    logic              done0_r, done0_nxt_s, done1_r, done1_nxt_s;
    logic              err0_r, err0_nxt_s, err1_r, err1_nxt_s;
    logic [DATA_W-1:0] rdata0_r, rdata0_nxt_s, rdata1_r, rdata1_nxt_s;

    logic              grant_valid_s;
    logic              winner_s;
    logic [3:0]        sel_starve_s;

    arb_priority_sel #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_sel (
        .req0        (req0),
        .req1        (req1),
        .starve_cnt  (starve_cnt_r),
        .grant_valid (grant_valid_s),
        .winner      (winner_s),
        .starve_nxt  (sel_starve_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and next-output computation; all outputs are registered below.
    always_comb begin
        state_nxt_s     = state_r;
        starve_nxt_s    = starve_cnt_r;
        timeout_nxt_s   = timeout_cnt_r;
        owner_nxt_s     = owner_r;
        mem_en_nxt_s    = 1'b0;
        mem_we_nxt_s    = mem_we_r;
        mem_addr_nxt_s  = mem_addr_r;
        mem_wdata_nxt_s = mem_wdata_r;
        done0_nxt_s     = 1'b0;
        done1_nxt_s     = 1'b0;
        err0_nxt_s      = 1'b0;
        err1_nxt_s      = 1'b0;
        rdata0_nxt_s    = rdata0_r;
        rdata1_nxt_s    = rdata1_r;

        case (state_r)
            ARB_IDLE: begin
                if (grant_valid_s) begin
                    state_nxt_s  = ARB_ACCESS;
                    owner_nxt_s  = winner_s;
                    starve_nxt_s = sel_starve_s;
                    mem_en_nxt_s = 1'b1;
                    if (winner_s == PORT_DMA) begin
                        mem_we_nxt_s    = we1;
                        mem_addr_nxt_s  = addr1;
                        mem_wdata_nxt_s = wdata1;
                    end else begin
                        mem_we_nxt_s    = we0;
                        mem_addr_nxt_s  = addr0;
                        mem_wdata_nxt_s = wdata0;
                    end
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end

            ARB_ACCESS: begin
                // mem_ready wins over a same-cycle timeout
                if (mem_ready) begin
                    state_nxt_s  = ARB_RESP;
                    mem_we_nxt_s = 1'b0;
                    if (owner_r == PORT_DMA) begin
                        done1_nxt_s = 1'b1;
                        if (!mem_we_r) begin
                            rdata1_nxt_s = mem_rdata;
                        end else begin
                            rdata1_nxt_s = rdata1_r;
                        end
                    end else begin
                        done0_nxt_s = 1'b1;
                        if (!mem_we_r) begin
                            rdata0_nxt_s = mem_rdata;
                        end else begin
                            rdata0_nxt_s = rdata0_r;
                        end
                    end
                end else if (timeout_cnt_r == TIMEOUT_LAST) begin
                    state_nxt_s   = ARB_RESP;
                    mem_we_nxt_s  = 1'b0;
                    timeout_nxt_s = timeout_cnt_r + 8'd1;
                    if (owner_r == PORT_DMA) begin
                        err1_nxt_s = 1'b1;
                    end else begin
                        err0_nxt_s = 1'b1;
                    end
                end else begin
                    mem_en_nxt_s  = 1'b1;
                    timeout_nxt_s = timeout_cnt_r + 8'd1;
                end
            end

            ARB_RESP: begin
                // Requests are ignored here so a still-held req is not re-granted
                state_nxt_s   = ARB_IDLE;
                timeout_nxt_s = 8'd0;
            end

            default: begin
                state_nxt_s   = ARB_IDLE;
                timeout_nxt_s = 8'd0;
                mem_we_nxt_s  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_r  <= 4'd0;
            timeout_cnt_r <= 8'd0;
            owner_r       <= PORT_CPU;
            mem_en_r      <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= '0;
            mem_wdata_r   <= '0;
            done0_r       <= 1'b0;
            done1_r       <= 1'b0;
            err0_r        <= 1'b0;
            err1_r        <= 1'b0;
            rdata0_r      <= '0;
            rdata1_r      <= '0;
        end else begin
            starve_cnt_r  <= starve_nxt_s;
            timeout_cnt_r <= timeout_nxt_s;
            owner_r       <= owner_nxt_s;
            mem_en_r      <= mem_en_nxt_s;
            mem_we_r      <= mem_we_nxt_s;
            mem_addr_r    <= mem_addr_nxt_s;
            mem_wdata_r   <= mem_wdata_nxt_s;
            done0_r       <= done0_nxt_s;
            done1_r       <= done1_nxt_s;
            err0_r        <= err0_nxt_s;
            err1_r        <= err1_nxt_s;
            rdata0_r      <= rdata0_nxt_s;
            rdata1_r      <= rdata1_nxt_s;
        end
    end

    assign done0     = done0_r;
    assign done1     = done1_r;
    assign err0      = err0_r;
    assign err1      = err1_r;
    assign rdata0    = rdata0_r;
    assign rdata1    = rdata1_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign owner     = owner_r;

endmodule : mem_arbiter
